ws2812_pixel_ser: RTL and testbench
===================================

// Module: ws2812_pixel_ser
// PURPOSE
//  Pixel-to-bit serializer sitting directly upstream of the WS2812 bit encoder.
//  Accepts 24-bit pixels via valid/ready, buffers one pixel, shifts bits MSB first,
//  and issues one bit request per bit. Each bit request waits for the encoder's
//  completion strobe. After the pixel flagged last, it holds the line idle for the
//  latch/reset gap, then signals frame completion.
// PARAMETERS
//  PIX_BITS     24          bits per pixel (shift length)
//  CNT_RST_GAP  16'd11000   idle cycles after last pixel (55 us @ 200 MHz, >50 us latch)
// PORTS
//  clk_in          in   1         system clock
//  rst_n_in        in   1         asynchronous reset, active-low
//  pix_valid_in    in   1         pixel word valid
//  pix_data_in     in   PIX_BITS  pixel word, {R,G,B} byte order
//  pix_last_in     in   1         qualifies pix_data_in as last pixel of frame
//  pix_ready_out   out  1         holding register empty; transfer = valid & ready
//  bit_done_in     in   1         1-cycle strobe: encoder finished current bit
//  bit_rdy_out     out  1         1-cycle strobe: start encoding bit_data_out
//  bit_data_out    out  1         current bit, stable from bit_rdy_out through bit_done_in
//  busy_out        out  1         high in any state except IDLE
//  frame_done_out  out  1         1-cycle strobe at end of reset gap
//  underrun_out    out  1         1-cycle strobe on entering WAIT_PIX
// BEHAVIOUR
//  Reset (async): all outputs 0 except pix_ready_out=1. State=IDLE.
//   Hold/shift regs, bit counter and gap counter cleared.
//   Reset mid-frame aborts the frame. No frame_done_out is produced.
//  Holding reg: loads on valid&ready. pix_ready_out = !hold_valid (registered).
//   Hold is freed the cycle it is copied into the shift reg.
//  FSM:
//   IDLE:     hold_valid -> LOAD.
//   LOAD:     shift <= hold, last_q <= hold_last, bit_idx <= PIX_BITS-1,
//             hold_valid <= 0 -> SEND.
//   SEND:     bit_rdy_out=1 for exactly this cycle.
//             bit_data_out <= shift[PIX_BITS-1] (set on entry) -> WAIT.
//   WAIT:     on bit_done_in: if bit_idx!=0 {shift<<=1; bit_idx--} -> SEND.
//             bit_idx==0 & last_q -> GAP.
//             bit_idx==0 & hold_valid -> LOAD.
//             bit_idx==0 & !hold_valid -> WAIT_PIX, with underrun_out pulsed.
//   WAIT_PIX: hold_valid -> LOAD (stall, line stays low; no timeout).
//   GAP:      gap_cnt counts 0..CNT_RST_GAP-1.
//             At terminal count: frame_done_out=1 for 1 cycle -> IDLE.
//             Pixels may still be accepted into hold during GAP.
//  Latency: pixel accepted at cycle t (hold empty, IDLE) -> bit_rdy_out at t+2.
//  Bit-to-bit: bit_done_in at t -> next bit_rdy_out at t+1.
//   Last bit's bit_done_in -> next pixel's first bit_rdy_out at t+2 (via LOAD).
//  bit_done_in outside WAIT is ignored.
//  bit_data_out is held until the next SEND; it is 0 in IDLE and GAP.
//  bit_idx width = $clog2(PIX_BITS). gap_cnt is 16-bit and never wraps.
//   It clears on GAP entry.
// CONFIGURATION
//  WS2812_GRB_ORDER_EN defined: LOAD reorders {R,G,B} -> {G,R,B} into the shift reg.
//   Wire order on the line is G7..G0,R7..R0,B7..B0.
//  Not defined: shift reg loads pix_data_in order unchanged, MSB first.
//  PIX_BITS must be 24 when WS2812_GRB_ORDER_EN is defined.
// TESTING
//  1 pixel 0xA50F3C, last=1, bit_done_in 3 cycles after each bit_rdy_out
//    -> 24 bit_rdy_out strobes; bit_data_out sequence 1010_0101_0000_1111_0011_1100.
//    -> CNT_RST_GAP cycles later, frame_done_out strobe; busy_out falls.
//  Same pixel with WS2812_GRB_ORDER_EN -> bit sequence 0x0FA53C MSB first.
//  3 back-to-back pixels, valid held high -> pix_ready_out drops/rises once per pixel.
//    -> exactly 72 bit_rdy_out; no underrun_out.
//  Pixel 1 (last=0), pixel 2 delayed 100 cycles after last bit_done_in
//    -> underrun_out one strobe; resumes with pixel 2; bit_rdy_out 2 cycles after accept.
//  Spurious bit_done_in in IDLE/SEND/GAP -> no state change, no extra bit_rdy_out.
//  rst_n_in low mid-pixel (bit 10) -> outputs to reset values immediately.
//    -> after release, new frame starts cleanly from bit 23.

Source files
------------

// File: rtl/ws2812_pixel_ser_if.sv
// ---------------------------------------------------------------------------
// ws2812_pixel_ser_if
// Pixel stream bundle feeding the WS2812 pixel serializer.
//   pix_valid_in   source -> serializer   pixel word valid
//   pix_data_in    source -> serializer   pixel word, {R,G,B} byte order
//   pix_last_in    source -> serializer   marks the last pixel of a frame
//   pix_ready_out  serializer -> source   holding register empty
// A transfer happens on every clock edge where valid and ready are both high.
// Modports: master = pixel source, slave = serializer.
// ---------------------------------------------------------------------------
interface ws2812_pixel_ser_if #(
  parameter int PIX_BITS = 24
);
  logic                pix_valid_in;
  logic [PIX_BITS-1:0] pix_data_in;
  logic                pix_last_in;
  logic                pix_ready_out;

  modport master (
    output pix_valid_in,
    output pix_data_in,
    output pix_last_in,
    input  pix_ready_out
  );

  modport slave (
    input  pix_valid_in,
    input  pix_data_in,
    input  pix_last_in,
    output pix_ready_out
  );
endinterface

// File: rtl/ws2812_pixel_ser.sv
// ---------------------------------------------------------------------------
// ws2812_pixel_ser
// Pixel-to-bit serializer sitting directly upstream of the WS2812 bit encoder.
// Buffers one 24-bit pixel, shifts it out MSB first as one bit request per
// bit, waits for the encoder's completion strobe after each request and, after
// the pixel flagged last, holds the line idle for the latch gap before
// signalling frame completion.
//
// Parameters
//   PIX_BITS      bits per pixel (shift length)
//   CNT_RST_GAP   idle cycles after the last pixel (11000 = 55 us @ 200 MHz)
//
// Ports
//   clk_in          in   system clock
//   rst_n_in        in   asynchronous reset, active-low
//   pix             slave modport of ws2812_pixel_ser_if (valid/ready pixel bus)
//   bit_done_in     in   1-cycle strobe: encoder finished the current bit
//   bit_rdy_out     out  1-cycle strobe: start encoding bit_data_out
//   bit_data_out    out  current bit, stable from bit_rdy_out through bit_done_in
//   busy_out        out  high in any state except IDLE
//   frame_done_out  out  1-cycle strobe at the end of the latch gap
//   underrun_out    out  1-cycle strobe when the next pixel was not ready in time
//
// Configuration
//   WS2812_GRB_ORDER_EN  when defined, LOAD reorders {R,G,B} into {G,R,B} so
//                        the line carries G7..G0,R7..R0,B7..B0. Requires
//                        PIX_BITS == 24. When undefined the pixel word is
//                        shifted out unchanged, MSB first.
// ---------------------------------------------------------------------------
module ws2812_pixel_ser #(
  parameter int          PIX_BITS    = 24,
  parameter logic [15:0] CNT_RST_GAP = 16'd11000
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  ws2812_pixel_ser_if.slave      pix,
  input  logic                   bit_done_in,
  output logic                   bit_rdy_out,
  output logic                   bit_data_out,
  output logic                   busy_out,
  output logic                   frame_done_out,
  output logic                   underrun_out
);

  localparam int IDX_W = $clog2(PIX_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_WAIT_PIX,
    ST_GAP
  } state_t;

  state_t              state_q;
  logic [PIX_BITS-1:0] hold_q;
  logic                hold_valid_q;
  logic                hold_last_q;
  logic [PIX_BITS-1:0] shift_q;
  logic                last_q;
  logic [IDX_W-1:0]    bit_idx_q;
  logic [15:0]         gap_cnt_q;
  logic [PIX_BITS-1:0] load_word;

  // Word copied into the shift register; the optional byte swap puts green
  // first on the wire without the pixel source having to know about it.
`ifdef WS2812_GRB_ORDER_EN
  assign load_word = {hold_q[15:8], hold_q[23:16], hold_q[7:0]};
`else
  assign load_word = hold_q;
`endif

  // One-entry holding register. It frees itself in LOAD, the cycle its
  // contents move into the shift register, so the next pixel can be accepted
  // while the current one is still being shifted out. Ready is kept as a
  // register (the inverse of hold_valid) rather than decoded combinationally.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hold_q            <= '0;
      hold_valid_q      <= 1'b0;
      hold_last_q       <= 1'b0;
      pix.pix_ready_out <= 1'b1;
    end else if (state_q == ST_LOAD) begin
      hold_valid_q      <= 1'b0;
      pix.pix_ready_out <= 1'b1;
    end else if (pix.pix_valid_in && pix.pix_ready_out) begin
      hold_q            <= pix.pix_data_in;
      hold_last_q       <= pix.pix_last_in;
      hold_valid_q      <= 1'b1;
      pix.pix_ready_out <= 1'b0;
    end
  end

  // Serializer FSM with registered outputs. Strobes are set on the edge that
  // enters the state they belong to, so bit_rdy_out and bit_data_out appear
  // together at the start of SEND. bit_done_in is only looked at in WAIT.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      last_q         <= 1'b0;
      bit_idx_q      <= '0;
      gap_cnt_q      <= '0;
      bit_rdy_out    <= 1'b0;
      bit_data_out   <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      underrun_out   <= 1'b0;
    end else begin
      bit_rdy_out    <= 1'b0;
      frame_done_out <= 1'b0;
      underrun_out   <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          bit_data_out <= 1'b0;
          if (hold_valid_q) begin
            state_q  <= ST_LOAD;
            busy_out <= 1'b1;
          end
        end

        ST_LOAD: begin
          shift_q      <= load_word;
          last_q       <= hold_last_q;
          bit_idx_q    <= IDX_W'(PIX_BITS - 1);
          bit_rdy_out  <= 1'b1;
          bit_data_out <= load_word[PIX_BITS-1];
          state_q      <= ST_SEND;
        end

        ST_SEND: begin
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (bit_done_in) begin
            if (bit_idx_q != '0) begin
              // The bit after the shift is shift_q[PIX_BITS-2] today.
              shift_q      <= shift_q << 1;
              bit_idx_q    <= bit_idx_q - IDX_W'(1);
              bit_rdy_out  <= 1'b1;
              bit_data_out <= shift_q[PIX_BITS-2];
              state_q      <= ST_SEND;
            end else if (last_q) begin
              gap_cnt_q    <= '0;
              bit_data_out <= 1'b0;
              state_q      <= ST_GAP;
            end else if (hold_valid_q) begin
              state_q <= ST_LOAD;
            end else begin
              underrun_out <= 1'b1;
              state_q      <= ST_WAIT_PIX;
            end
          end
        end

        // Stall with the last bit value held until the source catches up.
        ST_WAIT_PIX: begin
          if (hold_valid_q) begin
            state_q <= ST_LOAD;
          end
        end

        // Latch gap: CNT_RST_GAP cycles, then a single frame_done strobe.
        ST_GAP: begin
          bit_data_out <= 1'b0;
          if (gap_cnt_q == CNT_RST_GAP - 16'd1) begin
            frame_done_out <= 1'b1;
            busy_out       <= 1'b0;
            state_q        <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end

        default: begin
          busy_out <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_pixel_ser.sv
// ---------------------------------------------------------------------------
// tb_ws2812_pixel_ser
// Directed self-checking bench for ws2812_pixel_ser. A small encoder model
// answers every bit request with bit_done_in a fixed number of cycles later;
// a negedge monitor counts strobes and captures the serialized bits. Expected
// values are hand-computed pixel words (byte-swapped when
// WS2812_GRB_ORDER_EN is defined) and fixed cycle counts.
// ---------------------------------------------------------------------------
module tb_ws2812_pixel_ser;

  localparam int          PIX_BITS = 24;
  localparam logic [15:0] GAP      = 16'd40;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic bit_done_in;
  logic bit_rdy_out;
  logic bit_data_out;
  logic busy_out;
  logic frame_done_out;
  logic underrun_out;

  ws2812_pixel_ser_if #(.PIX_BITS(PIX_BITS)) pix ();

  ws2812_pixel_ser #(
    .PIX_BITS    (PIX_BITS),
    .CNT_RST_GAP (GAP)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .pix            (pix),
    .bit_done_in    (bit_done_in),
    .bit_rdy_out    (bit_rdy_out),
    .bit_data_out   (bit_data_out),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .underrun_out   (underrun_out)
  );

  always #5 clk_in = ~clk_in;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Count of rising clock edges so far; used to time strobes.
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Encoder model state
  int   enc_delay = 3;
  int   wait_left = 0;
  int   spur_req  = 0;
  int   spur_done = 0;
  logic send_spur = 1'b0;
  int   done_edge = -1000;

  // Monitor state
  int          rdy_cnt   = 0;
  int          fd_cnt    = 0;
  int          ur_cnt    = 0;
  int          rdy_edge  = 0;
  int          fd_edge   = 0;
  int          b2b0      = 0;
  int          b2b1      = 0;
  int          b2bx      = 0;
  int          rdy_rise  = 0;
  int          rdy_fall  = 0;
  logic        prev_rdy  = 1'b1;
  logic [71:0] cap       = '0;

  // Encoder: answers each bit request enc_delay cycles later with a one-cycle
  // done strobe; can also inject stray done strobes on request.
  initial begin
    bit_done_in = 1'b0;
    forever begin
      @(negedge clk_in);
      bit_done_in = 1'b0;
      if (!rst_n_in) wait_left = 0;
      if (wait_left > 0) begin
        wait_left--;
        if (wait_left == 0) begin
          bit_done_in = 1'b1;
          done_edge   = cyc + 1;
        end
      end
      if (bit_rdy_out) begin
        wait_left = enc_delay;
        if (send_spur) bit_done_in = 1'b1;
      end
      if (spur_req != spur_done) begin
        bit_done_in = 1'b1;
        spur_done++;
      end
    end
  end

  // Monitor: strobe counts, bit capture, bit-to-bit spacing, ready toggles.
  always @(negedge clk_in) begin
    if (bit_rdy_out) begin
      rdy_cnt++;
      rdy_edge = cyc;
      cap      = {cap[70:0], bit_data_out};
      if (cyc - done_edge == 0)      b2b0++;
      else if (cyc - done_edge == 1) b2b1++;
      else                           b2bx++;
    end
    if (frame_done_out) begin
      fd_cnt++;
      fd_edge = cyc;
    end
    if (underrun_out) ur_cnt++;
    if (pix.pix_ready_out === 1'b1 && prev_rdy === 1'b0) rdy_rise++;
    if (pix.pix_ready_out === 1'b0 && prev_rdy === 1'b1) rdy_fall++;
    prev_rdy = pix.pix_ready_out;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] expWord(input logic [23:0] w);
`ifdef WS2812_GRB_ORDER_EN
    return {w[15:8], w[23:16], w[7:0]};
`else
    return w;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the n-th following falling edge.
  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_in);
    #1;
  endtask

  // Offer one pixel; acc_edge is the cyc value of the accepting rising edge.
  task automatic applyStimulus(input logic [23:0] data, input logic last,
                               input bit keep_valid, output int acc_edge);
    int budget;
    budget   = 0;
    acc_edge = -1;
    pix.pix_data_in  = data;
    pix.pix_last_in  = last;
    pix.pix_valid_in = 1'b1;
    while (acc_edge < 0 && budget < 2000) begin
      if (pix.pix_ready_out) acc_edge = cyc + 1;
      waitCycles(1);
      budget++;
    end
    if (!keep_valid) pix.pix_valid_in = 1'b0;
    if (acc_edge < 0) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitRdyCount(input int target);
    int budget;
    budget = 0;
    while (rdy_cnt < target && budget < 3000) begin
      waitCycles(1);
      budget++;
    end
  endtask

  task automatic waitFrame(input string tag, input int fd0);
    int budget;
    budget = 0;
    while (fd_cnt == fd0 && budget < 3000) begin
      waitCycles(1);
      budget++;
    end
    checkOutput(tag, fd_cnt - fd0, 1);
  endtask

  int acc, r0, fd0, u0, b0, b1, rr0, rf0;

  initial begin
    rst_n_in         = 1'b0;
    pix.pix_valid_in = 1'b0;
    pix.pix_data_in  = '0;
    pix.pix_last_in  = 1'b0;
    waitCycles(3);

    // Reset values
    checkOutput("rst_ready",      pix.pix_ready_out, 1);
    checkOutput("rst_bit_rdy",    bit_rdy_out,       0);
    checkOutput("rst_bit_data",   bit_data_out,      0);
    checkOutput("rst_busy",       busy_out,          0);
    checkOutput("rst_frame_done", frame_done_out,    0);
    checkOutput("rst_underrun",   underrun_out,      0);
    rst_n_in = 1'b1;
    waitCycles(2);

    // Single last pixel
    r0 = rdy_cnt; fd0 = fd_cnt; u0 = ur_cnt;
    applyStimulus(24'hA50F3C, 1'b1, 1'b0, acc);
    waitRdyCount(r0 + 1);
    checkOutput("t1_latency", rdy_edge - acc, 2);
    checkOutput("t1_busy", busy_out, 1);
    waitFrame("t1_frame_done", fd0);
    checkOutput("t1_bits", rdy_cnt - r0, 24);
    checkOutput("t1_word", cap[23:0], expWord(24'hA50F3C));
    checkOutput("t1_gap", fd_edge - done_edge, GAP);
    checkOutput("t1_busy_end", busy_out, 0);
    checkOutput("t1_data_idle", bit_data_out, 0);
    checkOutput("t1_underrun", ur_cnt - u0, 0);

    // Three back-to-back pixels with valid held high
    waitCycles(3);
    r0 = rdy_cnt; fd0 = fd_cnt; u0 = ur_cnt; b0 = b2b0; b1 = b2b1;
    rr0 = rdy_rise; rf0 = rdy_fall;
    applyStimulus(24'h123456, 1'b0, 1'b1, acc);
    applyStimulus(24'h00FF81, 1'b0, 1'b1, acc);
    applyStimulus(24'h5AC3E7, 1'b1, 1'b0, acc);
    waitFrame("t2_frame_done", fd0);
    checkOutput("t2_bits", rdy_cnt - r0, 72);
    checkOutput("t2_words", cap, {expWord(24'h123456), expWord(24'h00FF81), expWord(24'h5AC3E7)});
    checkOutput("t2_underrun", ur_cnt - u0, 0);
    checkOutput("t2_b2b_same_pixel", b2b0 - b0, 69);
    checkOutput("t2_b2b_next_pixel", b2b1 - b1, 2);
    checkOutput("t2_ready_falls", rdy_fall - rf0, 3);
    checkOutput("t2_ready_rises", rdy_rise - rr0, 3);

    // Underrun: second pixel arrives 100 cycles after the first one drains
    waitCycles(3);
    r0 = rdy_cnt; fd0 = fd_cnt; u0 = ur_cnt;
    applyStimulus(24'h800001, 1'b0, 1'b0, acc);
    begin
      int budget;
      budget = 0;
      while (ur_cnt == u0 && budget < 1000) begin
        waitCycles(1);
        budget++;
      end
    end
    waitCycles(100);
    checkOutput("t3_underrun", ur_cnt - u0, 1);
    checkOutput("t3_busy_stall", busy_out, 1);
    checkOutput("t3_bits_first", rdy_cnt - r0, 24);
    checkOutput("t3_data_held", bit_data_out, 1);
    applyStimulus(24'h3C00A5, 1'b1, 1'b0, acc);
    waitRdyCount(r0 + 25);
    checkOutput("t3_latency", rdy_edge - acc, 2);
    waitFrame("t3_frame_done", fd0);
    checkOutput("t3_bits", rdy_cnt - r0, 48);
    checkOutput("t3_words", cap[47:0], {expWord(24'h800001), expWord(24'h3C00A5)});
    checkOutput("t3_underrun_once", ur_cnt - u0, 1);

    // Stray bit_done_in in IDLE, SEND and GAP
    waitCycles(3);
    r0 = rdy_cnt; fd0 = fd_cnt; u0 = ur_cnt;
    spur_req++;
    waitCycles(5);
    checkOutput("t4_idle_busy", busy_out, 0);
    checkOutput("t4_idle_bits", rdy_cnt - r0, 0);
    send_spur = 1'b1;
    applyStimulus(24'hC3A5F0, 1'b1, 1'b0, acc);
    waitRdyCount(r0 + 24);
    send_spur = 1'b0;
    waitCycles(8);
    spur_req++;
    waitFrame("t4_frame_done", fd0);
    checkOutput("t4_bits", rdy_cnt - r0, 24);
    checkOutput("t4_word", cap[23:0], expWord(24'hC3A5F0));
    checkOutput("t4_gap", fd_edge - done_edge, GAP);
    checkOutput("t4_underrun", ur_cnt - u0, 0);

    // Reset in the middle of a pixel, on the bit with index 10
    waitCycles(3);
    r0 = rdy_cnt; fd0 = fd_cnt;
    applyStimulus(24'hFFFFFF, 1'b1, 1'b0, acc);
    waitRdyCount(r0 + 14);
    rst_n_in = 1'b0;
    #1;
    checkOutput("t5_rst_ready",    pix.pix_ready_out, 1);
    checkOutput("t5_rst_bit_rdy",  bit_rdy_out,       0);
    checkOutput("t5_rst_bit_data", bit_data_out,      0);
    checkOutput("t5_rst_busy",     busy_out,          0);
    waitCycles(4);
    rst_n_in = 1'b1;
    waitCycles(60);
    checkOutput("t5_no_frame_done", fd_cnt - fd0, 0);
    checkOutput("t5_no_bits_after_abort", rdy_cnt - r0, 14);
    r0 = rdy_cnt; fd0 = fd_cnt;
    applyStimulus(24'h96C31E, 1'b1, 1'b0, acc);
    waitFrame("t5_frame_done", fd0);
    checkOutput("t5_bits", rdy_cnt - r0, 24);
    checkOutput("t5_word", cap[23:0], expWord(24'h96C31E));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
